// File: rtl/sram_pkg.sv
// Shared constants for the 16x4 scratch SRAM.
//   ADDR_W   : address width in bits
//   DATA_W   : word width in bits
//   DEPTH    : number of words, always 2**ADDR_W
//   RW_READ  : RW encoding for a read
//   RW_WRITE : RW encoding for a write
package sram_pkg;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 4;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/sram_word.sv
// One storage word of the scratch SRAM: a register with asynchronous
// active-low clear and a synchronous write enable.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low clear
//   we    : write enable
//   d     : write data
//   q     : stored word
module sram_word
   import sram_pkg::*;
#(
   parameter int unsigned W = DATA_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         we,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (we) begin
         q <= d;
      end
   end

endmodule

// File: rtl/sram_rw_4x16.sv
// Single-port 16x4 synchronous SRAM built from resettable flip-flops so the
// whole array clears asynchronously. One operation per rising edge: RW=0
// writes Din to mem[Address], RW=1 loads mem[Address] into Dout.
//   CLK     : clock, rising edge
//   RST     : asynchronous active-low reset, clears array and Dout
//   RW      : 1 = read, 0 = write
//   Address : word address
//   Din     : write data
//   Dout    : registered read data, holds across writes
module sram_rw_4x16
   import sram_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              RW,
   input  logic [ADDR_W-1:0] Address,
   input  logic [DATA_W-1:0] Din,
   output logic [DATA_W-1:0] Dout
);

   logic [DEPTH-1:0]             word_we;
   logic [DEPTH-1:0][DATA_W-1:0] words;
   logic [DATA_W-1:0]            rd_data;
   logic [DATA_W-1:0]            dout_q;

   // One-hot write enables, only during a write cycle
   always_comb begin
      word_we = '0;
      if (RW == RW_WRITE) begin
         word_we[Address] = 1'b1;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      sram_word #(
         .W (DATA_W)
      ) u_word (
         .clk   (CLK),
         .rst_n (RST),
         .we    (word_we[i]),
         .d     (Din),
         .q     (words[i])
      );
   end

   always_comb begin
      rd_data = words[Address];
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         dout_q <= '0;
      end else if (RW == RW_READ) begin
         dout_q <= rd_data;
      end
   end

   assign Dout = dout_q;

endmodule

// File: tb/tb_sram_rw_4x16.sv
module tb_sram_rw_4x16;

   logic       CLK;
   logic       RST;
   logic       RW;
   logic [3:0] Address;
   logic [3:0] Din;
   logic [3:0] Dout;

   int vectors;
   int miscompares;

   // Reference: plain array plus last-read value
   logic [3:0] ref_mem [16];
   logic [3:0] ref_dout;

   sram_rw_4x16 dut (
      .CLK     (CLK),
      .RST     (RST),
      .RW      (RW),
      .Address (Address),
      .Din     (Din),
      .Dout    (Dout)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      for (int i = 0; i < 16; i++) ref_mem[i] = 4'h0;
      ref_dout = 4'h0;
   endtask

   // Drive one operation, let one rising edge take it, update the model.
   task automatic apply(input logic rw, input logic [3:0] addr, input logic [3:0] din);
      @(negedge CLK);
      RW = rw;
      Address = addr;
      Din = din;
      @(posedge CLK);
      if (RST) begin
         if (rw) ref_dout = ref_mem[addr];
         else    ref_mem[addr] = din;
      end
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] addrs [3];
      addrs[0] = 4'd0; addrs[1] = 4'd6; addrs[2] = 4'd8;
      RST = 1'b1; RW = 1'b1; Address = 4'd0; Din = 4'd0;
      #2;
      RST = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (Dout !== 4'h0) begin
         $display("FAIL reset_async: Dout=%h required %h", Dout, 4'h0);
         miscompares++;
      end
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, addrs[i], 4'h0);
         vectors++;
         if (Dout !== 4'h0) begin
            $display("FAIL reset_read addr %0d: Dout=%h required %h", addrs[i], Dout, 4'h0);
            miscompares++;
         end
      end
   endtask

   task automatic test_write_read();
      apply(1'b0, 4'd0, 4'b1010);
      apply(1'b1, 4'd0, 4'h0);
      vectors++;
      if (Dout !== 4'b1010) begin
         $display("FAIL write_read addr 0: Dout=%b required %b", Dout, 4'b1010);
         miscompares++;
      end
      apply(1'b1, 4'd8, 4'h0);
      vectors++;
      if (Dout !== 4'b0000) begin
         $display("FAIL write_read addr 8: Dout=%b required %b", Dout, 4'b0000);
         miscompares++;
      end
   endtask

   task automatic test_isolation();
      apply(1'b0, 4'd8, 4'b0001);
      apply(1'b0, 4'd6, 4'b1111);
      apply(1'b1, 4'd8, 4'h0);
      vectors++;
      if (Dout !== 4'b0001) begin
         $display("FAIL isolation addr 8: Dout=%b required %b", Dout, 4'b0001);
         miscompares++;
      end
      apply(1'b1, 4'd6, 4'h0);
      vectors++;
      if (Dout !== 4'b1111) begin
         $display("FAIL isolation addr 6: Dout=%b required %b", Dout, 4'b1111);
         miscompares++;
      end
      apply(1'b1, 4'd0, 4'h0);
      vectors++;
      if (Dout !== 4'b1010) begin
         $display("FAIL isolation addr 0: Dout=%b required %b", Dout, 4'b1010);
         miscompares++;
      end
   endtask

   task automatic test_dout_hold();
      apply(1'b1, 4'd0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 4'd6, 4'(i + 3));
         vectors++;
         if (Dout !== 4'b1010) begin
            $display("FAIL dout_hold write %0d: Dout=%b required %b", i, Dout, 4'b1010);
            miscompares++;
         end
      end
      apply(1'b1, 4'd6, 4'h0);
      vectors++;
      if (Dout !== 4'd5) begin
         $display("FAIL dout_hold readback: Dout=%h required %h", Dout, 4'd5);
         miscompares++;
      end
   endtask

   task automatic test_sampling();
      @(negedge CLK);
      RW = 1'b0; Address = 4'd3; Din = 4'h5;
      #3;
      Address = 4'd7; Din = 4'h9;
      @(posedge CLK);
      ref_mem[7] = 4'h9;
      #1;
      Address = 4'd3; Din = 4'hF;   // glitch after the edge, before read setup
      apply(1'b1, 4'd3, 4'h0);
      vectors++;
      if (Dout !== 4'h0) begin
         $display("FAIL sampling addr 3: Dout=%h required %h", Dout, 4'h0);
         miscompares++;
      end
      apply(1'b1, 4'd7, 4'h0);
      vectors++;
      if (Dout !== 4'h9) begin
         $display("FAIL sampling addr 7: Dout=%h required %h", Dout, 4'h9);
         miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         logic [3:0] v;
         v = 4'($urandom_range(1, 15));
         apply(1'b0, 4'(i), v);
         apply(1'b1, 4'(i), 4'h0);
         vectors++;
         if (Dout !== v) begin
            $display("FAIL back_to_back addr %0d: Dout=%h required %h", i, Dout, v);
            miscompares++;
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         logic       rw;
         logic [3:0] a;
         logic [3:0] d;
         rw = 1'($urandom);
         a  = 4'($urandom);
         d  = 4'($urandom);
         apply(rw, a, d);
         vectors++;
         if (Dout !== ref_dout) begin
            $display("FAIL random op %0d rw=%b addr=%0d: Dout=%h required %h",
                     n, rw, a, Dout, ref_dout);
            miscompares++;
         end
      end
   endtask

   task automatic test_async_reset();
      apply(1'b0, 4'd0, 4'hA);
      apply(1'b0, 4'd6, 4'hF);
      apply(1'b0, 4'd8, 4'h1);
      apply(1'b1, 4'd6, 4'h0);
      @(negedge CLK);
      #2;
      RST = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (Dout !== 4'h0) begin
         $display("FAIL async_reset immediate: Dout=%h required %h", Dout, 4'h0);
         miscompares++;
      end
      // Write attempted on an edge while reset is held must be dropped
      apply(1'b0, 4'd6, 4'hF);
      apply(1'b1, 4'd8, 4'h0);
      @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < 16; i++) begin
         apply(1'b1, 4'(i), 4'h0);
         vectors++;
         if (Dout !== 4'h0) begin
            $display("FAIL async_reset clear addr %0d: Dout=%h required %h", i, Dout, 4'h0);
            miscompares++;
         end
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      model_reset();
      test_reset();
      test_write_read();
      test_isolation();
      test_dout_hold();
      test_sampling();
      test_back_to_back();
      test_random();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
